// File: rtl/fp32_pkg.sv
// Shared single-precision constants and divider FSM encodings.
package fp32_pkg;

  localparam int unsigned WIDTH         = 32;
  localparam int unsigned EXPONENTWIDTH = 8;
  localparam int unsigned MANTISSAWIDTH = 23;
  localparam int unsigned BIAS          = 127;
  localparam int unsigned QBITS         = 25;

  localparam logic [WIDTH-1:0]         QNAN    = 32'h7FC0_0000;
  localparam logic [EXPONENTWIDTH-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational operand classifier; subnormals are reported as zero.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [WIDTH-1:0]         x,
  output logic                     is_zero,
  output logic                     is_inf,
  output logic                     is_nan,
  output logic [MANTISSAWIDTH:0]   sig24
);

  logic [EXPONENTWIDTH-1:0] exp_f;
  logic [MANTISSAWIDTH-1:0] frac_f;
  logic                     unused_sign;

  assign exp_f       = x[WIDTH-2 -: EXPONENTWIDTH];
  assign frac_f      = x[MANTISSAWIDTH-1:0];
  assign unused_sign = x[WIDTH-1];

  assign is_zero = (exp_f == '0);
  assign is_inf  = (exp_f == EXP_MAX) && (frac_f == '0);
  assign is_nan  = (exp_f == EXP_MAX) && (frac_f != '0);
  assign sig24   = {1'b1, frac_f};

endmodule

// File: rtl/divide_f32_seq.sv
// Sequential fp32 divider: rst doubles as start, rdy flags a held result.
// Restoring radix-2 mantissa division, one quotient bit per clock, RNE rounding.
module divide_f32_seq
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             rdy,
  output logic [WIDTH-1:0] quo
);

  localparam int unsigned SIG_W = MANTISSAWIDTH + 1;
  localparam int unsigned REM_W = SIG_W + 2;
  localparam int unsigned EXP_W = 10;
  localparam int unsigned CNT_W = 5;

  state_t                   state;
  logic                     sgn;
  logic [SIG_W-1:0]         mb;
  logic [REM_W-1:0]         rem;
  logic [QBITS-1:0]         q;
  logic [CNT_W-1:0]         cnt;
  logic signed [EXP_W-1:0]  e;
  logic [WIDTH-1:0]         res;

  logic                     a_zero, a_inf, a_nan;
  logic                     b_zero, b_inf, b_nan;
  logic [SIG_W-1:0]         ma_c, mb_c;

  fp32_classify u_cls_num (
    .x       (num),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan),
    .sig24   (ma_c)
  );

  fp32_classify u_cls_den (
    .x       (den),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan),
    .sig24   (mb_c)
  );

  // Special-operand screening at load time
  logic             s_c;
  logic             special_c;
  logic [WIDTH-1:0] spec_val_c;
  logic [EXP_W-1:0] ea_c, eb_c;

  assign s_c  = num[WIDTH-1] ^ den[WIDTH-1];
  assign ea_c = EXP_W'(num[WIDTH-2 -: EXPONENTWIDTH]);
  assign eb_c = EXP_W'(den[WIDTH-2 -: EXPONENTWIDTH]);

  always_comb begin
    special_c  = 1'b1;
    spec_val_c = QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val_c = QNAN;
    end else if (a_inf || b_zero) begin
      spec_val_c = {s_c, EXP_MAX, MANTISSAWIDTH'(0)};
    end else if (a_zero || b_inf) begin
      spec_val_c = {s_c, (WIDTH-1)'(0)};
    end else begin
      special_c = 1'b0;
    end
  end

  // One restoring-division step
  logic                 ge_c;
  logic [REM_W-1:0]     diff_c;
  logic [REM_W-1:0]     rem_nxt_c;

  assign ge_c      = (rem >= REM_W'(mb));
  assign diff_c    = ge_c ? (rem - REM_W'(mb)) : rem;
  assign rem_nxt_c = {diff_c[REM_W-2:0], 1'b0};

  // Round-to-nearest-even and exponent range handling
  logic                     up_c;
  logic                     carry_c;
  logic [MANTISSAWIDTH-1:0] frac_c;
  logic signed [EXP_W-1:0]  e_rnd_c;
  logic [WIDTH-1:0]         rnd_res_c;

  always_comb begin
    up_c      = q[0] && ((rem != '0) || q[1]);
    carry_c   = up_c && (&q[QBITS-1:1]);
    frac_c    = q[MANTISSAWIDTH:1] + MANTISSAWIDTH'(up_c);
    e_rnd_c   = carry_c ? (e + EXP_W'(1)) : e;
    rnd_res_c = {sgn, e_rnd_c[EXPONENTWIDTH-1:0], frac_c};
    if (e_rnd_c >= $signed(EXP_W'(EXP_MAX))) begin
      rnd_res_c = {sgn, EXP_MAX, MANTISSAWIDTH'(0)};
    end else if (e_rnd_c <= $signed(EXP_W'(0))) begin
      rnd_res_c = {sgn, (WIDTH-1)'(0)};
    end
  end

  // Controller and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      sgn   <= 1'b0;
      mb    <= '0;
      rem   <= '0;
      q     <= '0;
      cnt   <= '0;
      e     <= '0;
      res   <= '0;
      rdy   <= 1'b0;
      quo   <= '0;
    end else begin
      case (state)
        LOAD: begin
          sgn <= s_c;
          mb  <= mb_c;
          cnt <= '0;
          q   <= '0;
          if (special_c) begin
            res   <= spec_val_c;
            state <= DONE;
          end else begin
            if (ma_c < mb_c) begin
              rem <= {1'b0, ma_c, 1'b0};
              e   <= $signed(ea_c - eb_c + EXP_W'(BIAS - 1));
            end else begin
              rem <= REM_W'(ma_c);
              e   <= $signed(ea_c - eb_c + EXP_W'(BIAS));
            end
            state <= DIV;
          end
        end
        DIV: begin
          q   <= {q[QBITS-2:0], ge_c};
          rem <= rem_nxt_c;
          if (cnt == CNT_W'(QBITS - 1)) begin
            state <= ROUND;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ROUND: begin
          quo   <= rnd_res_c;
          rdy   <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!rdy) begin
            quo <= res;
            rdy <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_f32_seq.sv
// Scoreboard bench for divide_f32_seq: expected quotient and latency queued per start.
module tb_divide_f32_seq;

  logic        clk;
  logic        rst;
  logic [31:0] num;
  logic [31:0] den;
  logic        rdy;
  logic [31:0] quo;

  int checks;
  int failures;

  typedef struct {
    string       tag;
    logic [31:0] quo;
    int          lat;
  } exp_t;

  exp_t sb[$];

  divide_f32_seq dut (
    .clk (clk),
    .rst (rst),
    .num (num),
    .den (den),
    .rdy (rdy),
    .quo (quo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Assert rst with new operands, release on a falling edge and wait for rdy
  task automatic run_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] exp_q, input int exp_lat);
    int   cyc;
    exp_t item;
    exp_t got;
    rst = 1'b1;
    num = n;
    den = d;
    #1;
    check({tag, "_rst_rdy"}, {31'd0, rdy}, 32'd0);
    check({tag, "_rst_quo"}, quo, 32'd0);
    item.tag = tag;
    item.quo = exp_q;
    item.lat = exp_lat;
    sb.push_back(item);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (!rdy && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    got = sb.pop_front();
    if (!rdy) begin
      check({got.tag, "_timeout"}, {31'd0, rdy}, 32'd1);
    end else begin
      check({got.tag, "_quo"}, quo, got.quo);
      check({got.tag, "_lat"}, 32'(cyc), 32'(got.lat));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    num = '0;
    den = '0;
    repeat (2) @(posedge clk);
    #1;
    check("por_rdy", {31'd0, rdy}, 32'd0);
    check("por_quo", quo, 32'd0);

    run_op("six_by_two",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27);

    // Result must hold while operands wander without a new start
    for (int i = 0; i < 10; i++) begin
      num = $urandom;
      den = $urandom;
      @(posedge clk);
      #1;
      check("hold_quo", quo, 32'h4040_0000);
      check("hold_rdy", {31'd0, rdy}, 32'd1);
    end

    run_op("one_third",    32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 27);
    run_op("neg_ten_five", 32'hC120_0000, 32'h40A0_0000, 32'hC000_0000, 27);
    run_op("div_zero",     32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 2);
    run_op("zero_zero",    32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 2);
    run_op("nan_num",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 2);
    run_op("inf_inf",      32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2);
    run_op("ninf_two",     32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 2);
    run_op("zero_neg",     32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 2);
    run_op("two_inf",      32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 2);
    run_op("overflow",     32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 27);
    run_op("underflow",    32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 27);

    // Abort a division in flight, then restart with different operands
    rst = 1'b1;
    num = 32'h40C0_0000;
    den = 32'h4000_0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("abort_busy_rdy", {31'd0, rdy}, 32'd0);
    rst = 1'b1;
    #1;
    check("abort_rdy", {31'd0, rdy}, 32'd0);
    check("abort_quo", quo, 32'd0);
    run_op("after_abort",  32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 27);

    // Async drop of a valid result on rst
    rst = 1'b1;
    #1;
    check("async_rdy", {31'd0, rdy}, 32'd0);
    check("async_quo", quo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
